// File: rtl/control_pkg.sv
// Shared constants for the multi-cycle RV64 control unit: FSM state type,
// opcode encodings, ALU operation codes and ALU operand-select codes.
package control_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StRWb,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StBranch
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_REG    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type ALU decoder.
// Ports:
//   funct3   - IR[14:12]
//   funct7_5 - IR[30]
//   alu_op   - ALU operation code for the R-type instruction
//   legal    - 1 when {funct7_5, funct3} is add/sub/and/or
module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case ({funct7_5, funct3})
      4'b0000: alu_op = ALU_ADD;
      4'b1000: alu_op = ALU_SUB;
      4'b0111: alu_op = ALU_AND;
      4'b0110: alu_op = ALU_OR;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle control unit for an RV64 datapath with one shared ALU and a
// unified instruction/data memory port. Supports add/sub/and/or, ld, sd, beq.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   opcode/funct3/funct7_5 - fields of the instruction register
//   zero                - ALU zero flag (used only for beq)
//   mem_ready           - memory finishes the current access this cycle
//   ALU_operation       - ALU op code; alu_src_a/alu_src_b - operand selects
//   IorD                - memory address select (0 PC, 1 ALUOut)
//   mem_read/mem_write  - memory strobes; ir_write - load IR and oldPC
//   pc_en/pc_source     - PC write enable and source (0 ALU, 1 ALUOut)
//   reg_write/mem_to_reg - register-file write and write-data select
//   instr_done          - pulse on the last cycle of every instruction
//   illegal             - pulse in decode for an unsupported encoding
module control_multiciclo
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALU_operation,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       pc_source,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [3:0] r_alu_op;
  logic       r_legal;

  alu_decoder u_alu_decoder (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (r_alu_op),
    .legal    (r_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ALU_operation = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    IorD          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_source     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    // Gating by rst_n keeps every strobe quiet during the reset cycle itself,
    // so an instruction aborted by reset never issues a write.
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = StDecode;
          end
        end
        StDecode: begin
          // ALUOut captures oldPC + imm as the speculative branch target.
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          state_d   = StFetch;
          if (opcode == OP_R && r_legal) begin
            state_d = StExecR;
          end else if (opcode == OP_LD || opcode == OP_SD) begin
            state_d = StMemAddr;
          end else if (opcode == OP_BEQ && funct3 == 3'b000) begin
            state_d = StBranch;
          end else begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        StExecR: begin
          alu_src_a     = SRC_A_REG;
          alu_src_b     = SRC_B_REG;
          ALU_operation = r_alu_op;
          state_d       = StRWb;
        end
        StRWb: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemAddr: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          state_d   = (opcode == OP_LD) ? StMemRd : StMemWr;
        end
        StMemRd: begin
          mem_read = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) state_d = StMemWb;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          mem_write = 1'b1;
          IorD      = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
        StBranch: begin
          alu_src_a     = SRC_A_REG;
          alu_src_b     = SRC_B_REG;
          ALU_operation = ALU_SUB;
          pc_source     = 1'b1;
          pc_en         = zero;
          instr_done    = 1'b1;
          state_d       = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: directed vector table, hand-written
// wait/reset sequences and randomized instructions against a step-list model.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic [3:0] ALU_operation;
  logic [1:0] alu_src_a, alu_src_b;
  logic       IorD, mem_read, mem_write, ir_write, pc_en, pc_source;
  logic       reg_write, mem_to_reg, instr_done, illegal;

  always #5 clk = ~clk;

  control_multiciclo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .ALU_operation (ALU_operation),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .IorD          (IorD),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_en         (pc_en),
    .pc_source     (pc_source),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .instr_done    (instr_done),
    .illegal       (illegal)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic iord, mr, mw, irw, pce, pcs, rw, m2r, done, ill;
  } outs_t;

  outs_t act;
  assign act = {ALU_operation, alu_src_a, alu_src_b, IorD, mem_read, mem_write, ir_write,
                pc_en, pc_source, reg_write, mem_to_reg, instr_done, illegal};

  localparam logic [6:0] R_OP = 7'b0110011, LD_OP = 7'b0000011;
  localparam logic [6:0] SD_OP = 7'b0100011, BEQ_OP = 7'b1100011;

  // Steps an instruction walks through; memory steps repeat until mem_ready.
  localparam int S_FETCH = 0, S_DEC = 1, S_DEC_ILL = 2, S_EXEC = 3, S_RWB = 4;
  localparam int S_ADDR = 5, S_RD = 6, S_MWB = 7, S_WR = 8, S_BR = 9;

  int n_checks = 0;
  int n_pass   = 0;
  int plan[$];

  task automatic chk_o(input string name, input outs_t a, input outs_t e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", name, a, e);
  endtask

  task automatic chk_i(input string name, input int a, input int e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, a, e);
  endtask

  function automatic logic [3:0] ref_rop(input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0) return f7 ? 4'b0110 : 4'b0010;
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd6) return 4'b0001;
    return 4'b0010;
  endfunction

  function automatic bit ref_legal(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == R_OP) return (f3 == 3'd0) || (!f7 && (f3 == 3'd6 || f3 == 3'd7));
    if (op == LD_OP || op == SD_OP) return 1'b1;
    if (op == BEQ_OP) return f3 == 3'd0;
    return 1'b0;
  endfunction

  function automatic void build_plan(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    plan = {S_FETCH};
    if (!ref_legal(op, f3, f7)) plan.push_back(S_DEC_ILL);
    else begin
      plan.push_back(S_DEC);
      if (op == R_OP) begin plan.push_back(S_EXEC); plan.push_back(S_RWB); end
      else if (op == LD_OP) begin plan.push_back(S_ADDR); plan.push_back(S_RD);
        plan.push_back(S_MWB); end
      else if (op == SD_OP) begin plan.push_back(S_ADDR); plan.push_back(S_WR); end
      else plan.push_back(S_BR);
    end
  endfunction

  function automatic bit is_mem(input int s);
    return s == S_FETCH || s == S_RD || s == S_WR;
  endfunction

  function automatic outs_t expect_step(input int s, input bit rdy, input bit z,
                                        input logic [3:0] rop);
    outs_t o = '0;
    o.alu = 4'b0010;
    case (s)
      S_FETCH: begin o.mr = 1; o.sb = 2'd1; o.irw = rdy; o.pce = rdy; end
      S_DEC: begin o.sa = 2'd2; o.sb = 2'd2; end
      S_DEC_ILL: begin o.sa = 2'd2; o.sb = 2'd2; o.ill = 1; o.done = 1; end
      S_EXEC: begin o.sa = 2'd1; o.sb = 2'd0; o.alu = rop; end
      S_RWB: begin o.rw = 1; o.done = 1; end
      S_ADDR: begin o.sa = 2'd1; o.sb = 2'd2; end
      S_RD: begin o.mr = 1; o.iord = 1; end
      S_MWB: begin o.rw = 1; o.m2r = 1; o.done = 1; end
      S_WR: begin o.mw = 1; o.iord = 1; o.done = rdy; end
      S_BR: begin o.sa = 2'd1; o.alu = 4'b0110; o.pcs = 1; o.pce = z; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Enter and leave at posedge+1 with the DUT in its fetch step.
  // fw/mw: scripted mem_ready-low cycles for fetch and the data access.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input bit zv, input bit rnd, input int fw, input int mw,
                           output int cycles, output outs_t last);
    int idx = 0;
    int waits = fw;
    bit rdy;
    build_plan(op, f3, f7);
    cycles = 0;
    last = '0;
    while (idx < plan.size()) begin
      opcode = op; funct3 = f3; funct7_5 = f7;
      if (rnd) rdy = ($urandom_range(0, 2) != 0);
      else if (is_mem(plan[idx]) && waits > 0) begin rdy = 1'b0; waits--; end
      else rdy = 1'b1;
      mem_ready = rdy;
      zero = rnd ? 1'($urandom_range(0, 1)) : zv;
      @(negedge clk);
      chk_o("cycle", act, expect_step(plan[idx], rdy, zero, ref_rop(f3, f7)));
      last = act;
      cycles++;
      if (!(is_mem(plan[idx]) && !rdy)) begin
        idx++;
        if (idx < plan.size() && is_mem(plan[idx])) waits = mw;
      end
      @(posedge clk); #1;
      if (cycles > 200) begin
        chk_i("cycle_budget", cycles, 200);
        break;
      end
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; bit z;
    int cyc; logic [4:0] fin;  // fin = {done, illegal, reg_write, pc_en, mem_write}
  } vec_t;

  vec_t  vecs[$];
  outs_t last, rst_v;
  int    cyc;

  initial begin
    rst_v = '0;
    rst_v.alu = 4'b0010;
    vecs = '{
      '{R_OP, 3'd0, 1'b0, 1'b0, 4, 5'b10100},        // add
      '{R_OP, 3'd0, 1'b1, 1'b0, 4, 5'b10100},        // sub
      '{R_OP, 3'd7, 1'b0, 1'b0, 4, 5'b10100},        // and
      '{R_OP, 3'd6, 1'b0, 1'b0, 4, 5'b10100},        // or
      '{R_OP, 3'd4, 1'b0, 1'b0, 2, 5'b11000},        // xor unsupported
      '{R_OP, 3'd7, 1'b1, 1'b0, 2, 5'b11000},        // bad funct7
      '{BEQ_OP, 3'd0, 1'b0, 1'b1, 3, 5'b10010},      // beq taken
      '{BEQ_OP, 3'd0, 1'b0, 1'b0, 3, 5'b10000},      // beq not taken
      '{BEQ_OP, 3'd1, 1'b0, 1'b1, 2, 5'b11000},      // bne unsupported
      '{LD_OP, 3'd3, 1'b0, 1'b0, 5, 5'b10100},       // ld
      '{SD_OP, 3'd3, 1'b0, 1'b0, 4, 5'b10001},       // sd
      '{7'b1111111, 3'd0, 1'b0, 1'b0, 2, 5'b11000}   // illegal opcode
    };

    // Reset held 3 cycles with mem_ready high: everything quiet.
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    opcode = R_OP; funct3 = 3'd0; funct7_5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_o("reset_quiet", act, rst_v);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, 1'b0, 0, 0, cyc, last);
      chk_i($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      chk_i($sformatf("vec%0d_final", i), {last.done, last.ill, last.rw, last.pce, last.mw},
            vecs[i].fin);
    end

    // ld with 2 fetch waits and 3 read waits.
    run_instr(LD_OP, 3'd3, 1'b0, 1'b0, 1'b0, 2, 3, cyc, last);
    chk_i("ld_wait_cycles", cyc, 10);
    chk_i("ld_wait_final", {last.rw, last.m2r, last.done}, 3'b111);

    // Reset while sd waits in its write step.
    opcode = SD_OP; funct3 = 3'd3; funct7_5 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk_o("sd_wait", act, expect_step(S_WR, 1'b0, 1'b0, 4'b0010));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_o("sd_reset_cycle", act, rst_v);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_o("post_reset_fetch", act, expect_step(S_FETCH, 1'b0, 1'b0, 4'b0010));
    @(posedge clk); #1;

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic f7;
      int kind;
      kind = $urandom_range(0, 5);
      f7 = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case (kind)
        0: op = R_OP;
        1: op = LD_OP;
        2: op = SD_OP;
        3: begin op = BEQ_OP; if ($urandom_range(0, 3) != 0) f3 = 3'd0; end
        4: op = 7'($urandom);
        default: begin
          op = R_OP; f7 = 1'b0;
          f3 = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd7;
        end
      endcase
      run_instr(op, f3, f7, 1'b0, 1'b1, 0, 0, cyc, last);
      chk_i("rand_done", int'(last.done), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
